// File: rtl/big_core_pkg.sv
`default_nettype none
// ============================================================================
// big_core_pkg : shared types and constants for the big_core keyboard path
// Rev 1.0
// ============================================================================
package big_core_pkg;

  localparam logic [7:0] KBD_BREAK_CODE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } t_ps2_state;

  typedef struct packed {
    logic kbd_pop;
    logic kbd_scanf_en;
  } t_kbd_ctrl;

  typedef struct packed {
    logic [7:0] kbd_data;
    logic       kbd_ready;
  } t_kbd_data_rd;

endpackage
`default_nettype wire

// File: rtl/big_core_kbd_fifo.sv
`default_nettype none
// ============================================================================
// big_core_kbd_fifo : scan-code FIFO with registered head and empty flag
// Rev 1.0
// ============================================================================
module big_core_kbd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             empty_q, empty_d;
  logic             do_pop, do_push;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full FIFO still accepts a push when a real pop frees a slot this cycle.
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    empty_d  = (count_d == '0);
    head_d   = (do_push && (wr_ptr_q == rd_ptr_d)) ? din : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      empty_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      empty_q  <= empty_d;
    end
  end

  assign head  = head_q;
  assign empty = empty_q;
  assign full  = (count_q == FULL_CNT);

endmodule
`default_nettype wire

// File: rtl/big_core_kbd.sv
`default_nettype none
// ============================================================================
// big_core_kbd : PS/2 keyboard receiver with scan-code FIFO
// Optional break-code filter: BIG_CORE_KBD_BREAK_FILTER_EN.  Rev 1.0
// ============================================================================
module big_core_kbd
  import big_core_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 100000
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  input  t_kbd_ctrl    kbd_ctrl,
  output t_kbd_data_rd kbd_data_rd,
  output logic         kbd_frame_err,
  output logic         kbd_overflow
);

  localparam int TW = $clog2(TIMEOUT + 1);

  t_ps2_state  state_q, state_d;
  logic        clk_meta_q, clk_sync_q, clk_prev_q;
  logic        data_meta_q, data_sync_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        frame_err_q, frame_err_d;
  logic        overflow_q, overflow_d;
  logic        fall, tmo_hit, frame_ok, keep, push;
  logic [7:0]  fifo_head;
  logic        fifo_empty, fifo_full;

  assign fall = clk_prev_q & ~clk_sync_q;

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    tmo_hit = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT - 1));
    tmo_d   = (fall || state_q == IDLE || tmo_hit) ? '0 : tmo_q + TW'(1);
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall && !data_sync_q)           state_d = DATA;
      DATA:    if (fall && bit_cnt_q == 3'd7)      state_d = PARITY;
      PARITY:  if (fall)                           state_d = STOP;
      STOP:    if (fall)                           state_d = IDLE;
      default:                                     state_d = IDLE;
    endcase
    if (tmo_hit) state_d = IDLE;
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    frame_ok    = 1'b0;
    frame_err_d = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: begin
          bit_cnt_d   = 3'd0;
          frame_err_d = data_sync_q;
        end
        DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: parity_d = data_sync_q;
        STOP: begin
          frame_ok    = data_sync_q & (^shift_q ^ parity_q);
          frame_err_d = ~frame_ok;
        end
        default: ;
      endcase
    end
  end

`ifdef BIG_CORE_KBD_BREAK_FILTER_EN
  logic break_q, break_d;

  // A break prefix and the byte that follows it never reach the FIFO.
  always_comb begin
    break_d = break_q;
    keep    = 1'b0;
    if (frame_ok) begin
      if (shift_q == KBD_BREAK_CODE) break_d = 1'b1;
      else if (break_q)              break_d = 1'b0;
      else                           keep    = 1'b1;
    end
    if (tmo_hit) break_d = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) break_q <= 1'b0;
    else     break_q <= break_d;
  end
`else
  assign keep = frame_ok;
`endif

  assign push       = keep & kbd_ctrl.kbd_scanf_en;
  assign overflow_d = overflow_q | (push & fifo_full & ~kbd_ctrl.kbd_pop);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  big_core_kbd_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (push),
    .din   (shift_q),
    .pop   (kbd_ctrl.kbd_pop),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign kbd_data_rd   = {fifo_head, ~fifo_empty};
  assign kbd_frame_err = frame_err_q;
  assign kbd_overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_big_core_kbd.sv
`default_nettype none
// tb_big_core_kbd : randomized PS/2 frames checked against a queue-based model
module tb_big_core_kbd;
  import big_core_pkg::*;

  localparam int DEPTH = 16;
  localparam int TMO   = 64;
  localparam int HALF  = 5;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         ps2_clk = 1'b1;
  logic         ps2_data = 1'b1;
  t_kbd_ctrl    kbd_ctrl = '0;
  t_kbd_data_rd kbd_data_rd;
  logic         kbd_frame_err;
  logic         kbd_overflow;

  int   n_vec = 0;
  int   n_err = 0;
  int   err_pulses = 0;
  logic [7:0] mq[$];
  bit   m_ovf = 1'b0;
  bit   m_brk = 1'b0;

  big_core_kbd #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .kbd_ctrl      (kbd_ctrl),
    .kbd_data_rd   (kbd_data_rd),
    .kbd_frame_err (kbd_frame_err),
    .kbd_overflow  (kbd_overflow)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (kbd_frame_err) err_pulses <= err_pulses + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model: a received byte either fills a queue slot or sets overflow.
  function automatic void model_rx(input logic [7:0] d, input bit valid);
    if (!valid) return;
`ifdef BIG_CORE_KBD_BREAK_FILTER_EN
    if (d == 8'hF0) begin m_brk = 1'b1; return; end
    if (m_brk) begin m_brk = 1'b0; return; end
`endif
    if (!kbd_ctrl.kbd_scanf_en) return;
    if (mq.size() < DEPTH) mq.push_back(d);
    else m_ovf = 1'b1;
  endfunction

  task automatic ps2_bit(input logic b, input bit pop_at_edge);
    @(negedge Clk); ps2_data = b;
    repeat (HALF) @(negedge Clk);
    ps2_clk = 1'b0;
    if (pop_at_edge) begin
      repeat (2) @(posedge Clk);
      @(negedge Clk); kbd_ctrl.kbd_pop = 1'b1;
      @(negedge Clk); kbd_ctrl.kbd_pop = 1'b0;
      repeat (HALF - 2) @(negedge Clk);
    end else begin
      repeat (HALF) @(negedge Clk);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input bit pop_at_stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
    ps2_bit((~^d) ^ bad_par, 1'b0);
    ps2_bit(~bad_stop, pop_at_stop);
    repeat (4) @(negedge Clk);
  endtask

  task automatic do_pop();
    @(negedge Clk); kbd_ctrl.kbd_pop = 1'b1;
    @(negedge Clk); kbd_ctrl.kbd_pop = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (5) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    n_vec++; if (kbd_data_rd.kbd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", kbd_data_rd.kbd_ready); end
    n_vec++; if (kbd_data_rd.kbd_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h exp 00", kbd_data_rd.kbd_data); end
    n_vec++; if (kbd_frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got %b exp 0", kbd_frame_err); end
    n_vec++; if (kbd_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b exp 0", kbd_overflow); end
  endtask

  task automatic test_valid_frame();
    int e0 = err_pulses;
    kbd_ctrl.kbd_scanf_en = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0); model_rx(8'h1C, 1'b1);
    n_vec++; if (kbd_data_rd.kbd_ready !== 1'b1) begin n_err++; $display("FAIL valid_ready got %b exp 1", kbd_data_rd.kbd_ready); end
    n_vec++; if (kbd_data_rd.kbd_data !== 8'h1C) begin n_err++; $display("FAIL valid_data got %h exp 1c", kbd_data_rd.kbd_data); end
    n_vec++; if (err_pulses - e0 !== 0) begin n_err++; $display("FAIL valid_no_err got %0d exp 0", err_pulses - e0); end
    do_pop();
    n_vec++; if (kbd_data_rd.kbd_ready !== 1'b0) begin n_err++; $display("FAIL valid_pop_ready got %b exp 0", kbd_data_rd.kbd_ready); end
  endtask

  task automatic test_bad_frames();
    int e0 = err_pulses;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    n_vec++; if (err_pulses - e0 !== 1) begin n_err++; $display("FAIL bad_parity_pulse got %0d exp 1", err_pulses - e0); end
    n_vec++; if (kbd_data_rd.kbd_ready !== 1'b0) begin n_err++; $display("FAIL bad_parity_ready got %b exp 0", kbd_data_rd.kbd_ready); end
    ps2_bit(1'b1, 1'b0);
    repeat (4) @(negedge Clk);
    n_vec++; if (err_pulses - e0 !== 2) begin n_err++; $display("FAIL bad_start_pulse got %0d exp 2", err_pulses - e0); end
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    n_vec++; if (err_pulses - e0 !== 3) begin n_err++; $display("FAIL bad_stop_pulse got %0d exp 3", err_pulses - e0); end
    n_vec++; if (kbd_data_rd.kbd_ready !== 1'b0) begin n_err++; $display("FAIL bad_stop_ready got %b exp 0", kbd_data_rd.kbd_ready); end
    send_frame(8'h32, 1'b0, 1'b0, 1'b0); model_rx(8'h32, 1'b1);
    n_vec++; if (kbd_data_rd.kbd_data !== 8'h32) begin n_err++; $display("FAIL after_bad_data got %h exp 32", kbd_data_rd.kbd_data); end
    do_pop();
  endtask

  task automatic test_timeout();
    int e0 = err_pulses;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1), 1'b0);
    repeat (TMO + 20) @(negedge Clk);
    m_brk = 1'b0;
    n_vec++; if (err_pulses - e0 !== 0) begin n_err++; $display("FAIL timeout_no_err got %0d exp 0", err_pulses - e0); end
    n_vec++; if (kbd_data_rd.kbd_ready !== 1'b0) begin n_err++; $display("FAIL timeout_ready got %b exp 0", kbd_data_rd.kbd_ready); end
    send_frame(8'h32, 1'b0, 1'b0, 1'b0); model_rx(8'h32, 1'b1);
    n_vec++; if (kbd_data_rd.kbd_data !== 8'h32) begin n_err++; $display("FAIL timeout_next_data got %h exp 32", kbd_data_rd.kbd_data); end
    n_vec++; if (err_pulses - e0 !== 0) begin n_err++; $display("FAIL timeout_next_err got %0d exp 0", err_pulses - e0); end
    do_pop();
  endtask

  task automatic test_capture_disabled();
    kbd_ctrl.kbd_scanf_en = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0); model_rx(8'h1C, 1'b1);
    n_vec++; if (kbd_data_rd.kbd_ready !== 1'b0) begin n_err++; $display("FAIL disabled_ready got %b exp 0", kbd_data_rd.kbd_ready); end
    kbd_ctrl.kbd_scanf_en = 1'b1;
  endtask

  task automatic test_collision();
    send_frame(8'h11, 1'b0, 1'b0, 1'b0); model_rx(8'h11, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    if (mq.size() > 0) void'(mq.pop_front());
    model_rx(8'h22, 1'b1);
    n_vec++; if (kbd_data_rd.kbd_ready !== 1'b1) begin n_err++; $display("FAIL collision_ready got %b exp 1", kbd_data_rd.kbd_ready); end
    n_vec++; if (kbd_data_rd.kbd_data !== 8'h22) begin n_err++; $display("FAIL collision_data got %h exp 22", kbd_data_rd.kbd_data); end
    do_pop();
    n_vec++; if (kbd_data_rd.kbd_ready !== 1'b0) begin n_err++; $display("FAIL collision_count got ready %b exp 0", kbd_data_rd.kbd_ready); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 17; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1'b0); model_rx(8'(i), 1'b1);
    end
    n_vec++; if (kbd_overflow !== 1'b1) begin n_err++; $display("FAIL overflow_flag got %b exp 1", kbd_overflow); end
    for (int i = 1; i <= 16; i++) begin
      n_vec++; if (kbd_data_rd.kbd_data !== 8'(i)) begin n_err++; $display("FAIL overflow_order[%0d] got %h exp %h", i, kbd_data_rd.kbd_data, 8'(i)); end
      do_pop();
    end
    n_vec++; if (kbd_data_rd.kbd_ready !== 1'b0) begin n_err++; $display("FAIL overflow_drain got %b exp 0", kbd_data_rd.kbd_ready); end
    n_vec++; if (kbd_overflow !== 1'b1) begin n_err++; $display("FAIL overflow_sticky got %b exp 1", kbd_overflow); end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h44, 1'b0, 1'b0, 1'b0); model_rx(8'h44, 1'b1);
    n_vec++; if (kbd_data_rd.kbd_ready !== 1'b1) begin n_err++; $display("FAIL pre_reset_ready got %b exp 1", kbd_data_rd.kbd_ready); end
    ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0); ps2_bit(1'b0, 1'b0);
    @(negedge Clk); Rst = 1'b1;
    repeat (2) @(negedge Clk); Rst = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_brk = 1'b0;
    @(negedge Clk);
    n_vec++; if (kbd_data_rd.kbd_ready !== 1'b0) begin n_err++; $display("FAIL midreset_ready got %b exp 0", kbd_data_rd.kbd_ready); end
    n_vec++; if (kbd_overflow !== 1'b0) begin n_err++; $display("FAIL midreset_overflow got %b exp 0", kbd_overflow); end
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0); model_rx(8'h5A, 1'b1);
    n_vec++; if (kbd_data_rd.kbd_data !== 8'h5A) begin n_err++; $display("FAIL midreset_next got %h exp 5a", kbd_data_rd.kbd_data); end
    do_pop();
  endtask

  task automatic test_break_filter();
    logic [7:0] exp_q[$];
`ifdef BIG_CORE_KBD_BREAK_FILTER_EN
    exp_q = '{8'h32};
`else
    exp_q = '{8'hF0, 8'h1C, 8'h32};
`endif
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0); model_rx(8'hF0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0); model_rx(8'h1C, 1'b1);
    send_frame(8'h32, 1'b0, 1'b0, 1'b0); model_rx(8'h32, 1'b1);
    foreach (exp_q[i]) begin
      n_vec++; if (kbd_data_rd.kbd_ready !== 1'b1 || kbd_data_rd.kbd_data !== exp_q[i]) begin
        n_err++; $display("FAIL break_filter[%0d] got rdy=%b data=%h exp rdy=1 data=%h", i, kbd_data_rd.kbd_ready, kbd_data_rd.kbd_data, exp_q[i]);
      end
      do_pop();
    end
    n_vec++; if (kbd_data_rd.kbd_ready !== 1'b0) begin n_err++; $display("FAIL break_filter_empty got %b exp 0", kbd_data_rd.kbd_ready); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int e0 = err_pulses;
      int kind = $urandom_range(0, 5);
      logic [7:0] d = ($urandom_range(0, 7) == 0) ? 8'hF0 : 8'($urandom_range(0, 255));
      kbd_ctrl.kbd_scanf_en = ($urandom_range(0, 3) != 0);
      send_frame(d, kind == 0, kind == 1, 1'b0);
      model_rx(d, kind > 1);
      n_vec++; if (err_pulses - e0 !== ((kind <= 1) ? 1 : 0)) begin n_err++; $display("FAIL rnd_err[%0d] got %0d exp %0d", n, err_pulses - e0, (kind <= 1) ? 1 : 0); end
      n_vec++; if (kbd_data_rd.kbd_ready !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_ready[%0d] got %b exp %b", n, kbd_data_rd.kbd_ready, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_vec++; if (kbd_data_rd.kbd_data !== mq[0]) begin n_err++; $display("FAIL rnd_data[%0d] got %h exp %h", n, kbd_data_rd.kbd_data, mq[0]); end
      end
      n_vec++; if (kbd_overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf[%0d] got %b exp %b", n, kbd_overflow, m_ovf); end
      if ($urandom_range(0, 1) == 1) begin
        do_pop();
        n_vec++; if (kbd_data_rd.kbd_ready !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_pop_ready[%0d] got %b exp %b", n, kbd_data_rd.kbd_ready, mq.size() != 0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_frames();
    test_timeout();
    test_capture_disabled();
    test_collision();
    test_overflow();
    test_reset_mid_frame();
    test_break_filter();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
